// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the boot-time program loader.
//   state_e - loader FSM states
//   MAGIC   - frame start byte
//   ByteW / WordW / CountW - stream byte, instruction word and word-count widths
package prog_loader_pkg;

    localparam int unsigned ByteW  = 8;
    localparam int unsigned WordW  = 32;
    localparam int unsigned CountW = 16;

    localparam logic [ByteW-1:0] MAGIC = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StCntHi,
        StCntLo,
        StData,
        StChk,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// byte_packer: assembles four stream bytes into one big-endian 32-bit word.
//   clk_i, rst_ni  - clock, async active-low reset
//   clear_i        - drop any partial word and restart at byte 0
//   byte_valid_i   - byte_i is accepted this cycle
//   byte_i         - incoming byte (first byte of a word lands in bits 31:24)
//   word_o         - assembled word, valid while word_ready_o is high
//   word_ready_o   - combinational: this cycle's byte completes a word
module byte_packer
    import prog_loader_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             byte_valid_i,
    input  logic [ByteW-1:0] byte_i,
    output logic [WordW-1:0] word_o,
    output logic             word_ready_o
);

    logic [1:0]             idx_q;
    logic [WordW-ByteW-1:0] shift_q;

    // The 4th byte is not stored; it is merged straight into the output word.
    assign word_ready_o = byte_valid_i && (idx_q == 2'd3);
    assign word_o       = {shift_q, byte_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q   <= 2'd0;
            shift_q <= '0;
        end else if (clear_i) begin
            idx_q   <= 2'd0;
            shift_q <= '0;
        end else if (byte_valid_i) begin
            idx_q   <= idx_q + 2'd1;
            shift_q <= {shift_q[WordW-2*ByteW-1:0], byte_i};
        end
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: boot-time instruction-memory writer. Parses a framed byte stream
// (A5, count_hi, count_lo, 4*N data bytes [, checksum]), writes big-endian words
// to consecutive word addresses from BASE_ADDR and releases the CPU when done.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
//   clk_i, rst_ni          - clock, async active-low reset
//   in_valid_i, in_data_i  - byte stream input
//   in_ready_o             - byte accepted when in_valid_i & in_ready_o
//   imem_we_o, imem_addr_o, imem_wdata_o - one-cycle program memory write
//   cpu_hold_o             - hold CPU while high
//   done_o, error_o        - sticky success / bad frame flags
//   words_written_o        - words written so far
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    input  logic [ByteW-1:0]  in_data_i,
    output logic              in_ready_o,
    output logic              imem_we_o,
    output logic [31:0]       imem_addr_o,
    output logic [WordW-1:0]  imem_wdata_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              error_o,
    output logic [CountW-1:0] words_written_o
);

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_e EndState = StChk;
`else
    localparam state_e EndState = StDone;
`endif

    state_e            state_q, state_d;
    logic [ByteW-1:0]  cnt_hi_q;
    logic [CountW-1:0] count_q, words_q;
    logic              in_ready_q, imem_we_q, cpu_hold_q, done_q, error_q;
    logic [31:0]       imem_addr_q;
    logic [WordW-1:0]  imem_wdata_q;

    logic              fire, data_fire, word_ready, last_word;
    logic [CountW-1:0] hdr_count, words_inc;
    logic [WordW-1:0]  packed_word;

    assign fire      = in_valid_i && in_ready_q;
    assign data_fire = fire && (state_q == StData);
    assign hdr_count = {cnt_hi_q, in_data_i};
    assign words_inc = words_q + 16'd1;
    assign last_word = word_ready && (words_inc == count_q);

    // Packer is held clear outside DATA so every frame starts at byte 0.
    byte_packer u_packer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (state_q != StData),
        .byte_valid_i (data_fire),
        .byte_i       (in_data_i),
        .word_o       (packed_word),
        .word_ready_o (word_ready)
    );

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [ByteW-1:0] csum_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            csum_q <= '0;
        end else if (fire && state_q == StCntLo) begin
            csum_q <= '0;
        end else if (data_fire) begin
            csum_q <= csum_q ^ in_data_i;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        if (fire) begin
            unique case (state_q)
                StIdle:  if (in_data_i == MAGIC) state_d = StCntHi;
                StCntHi: state_d = StCntLo;
                StCntLo: begin
                    if ({16'd0, hdr_count} > MAX_WORDS) state_d = StErr;
                    else if (hdr_count == '0)           state_d = EndState;
                    else                                state_d = StData;
                end
                StData:  if (last_word) state_d = EndState;
`ifdef PROG_LOADER_CHECKSUM_EN
                StChk:   state_d = (in_data_i == csum_q) ? StDone : StErr;
`endif
                default: state_d = state_q;
            endcase
        end
    end

    // Status outputs are registered from the next state so they change together
    // with the state; the final data write and the release share one edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cnt_hi_q     <= '0;
            count_q      <= '0;
            words_q      <= '0;
            in_ready_q   <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_ADDR;
            imem_wdata_q <= '0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != StDone);
            cpu_hold_q <= (state_d != StDone);
            done_q     <= (state_d == StDone);
            error_q    <= (state_d == StErr);
            imem_we_q  <= 1'b0;
            if (fire && state_q == StCntHi) cnt_hi_q <= in_data_i;
            if (fire && state_q == StCntLo) count_q <= hdr_count;
            if (data_fire && word_ready) begin
                imem_we_q    <= 1'b1;
                imem_addr_q  <= BASE_ADDR + {14'd0, words_q, 2'b00};
                imem_wdata_q <= packed_word;
                words_q      <= words_inc;
            end
        end
    end

    assign in_ready_o      = in_ready_q;
    assign imem_we_o       = imem_we_q;
    assign imem_addr_o     = imem_addr_q;
    assign imem_wdata_o    = imem_wdata_q;
    assign cpu_hold_o      = cpu_hold_q;
    assign done_o          = done_q;
    assign error_o         = error_q;
    assign words_written_o = words_q;

endmodule
